nlc_sample_feeder: RTL

Upstream feeder for the ADC non-linearity correction engine. It buffers raw 21-bit ADC counts arriving at up to one per clock in a small FIFO. It issues them to the engine one at a time as a single-cycle valid pulse, and holds off the next issue until the engine reports completion. A watchdog recovers the feeder if the engine never completes, and sticky flags report dropped samples and timeouts.

---
 rtl/nlc_sample_feeder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/nlc_sample_feeder.sv
// nlc_sample_feeder: buffers raw ADC counts in a small FIFO and issues them
// one at a time to the non-linearity correction engine. A new sample is only
// issued once the engine reports completion. A watchdog abandons a sample if
// completion never arrives.
//
// Handshake: upstream offers i_x with i_srdyi and there is no back-pressure.
// A sample offered while o_full=1 is dropped and flagged in o_overflow.
// Downstream sees a one-cycle o_srdyo pulse with o_x stable. o_x is held
// until the next issue. The engine acknowledges with a one-cycle i_done.
module nlc_sample_feeder #(
  parameter int DEPTH   = 8,
  parameter int XW      = 21,
  parameter int TIMEOUT = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [XW-1:0]              i_x,
  input  logic                       i_srdyi,
  input  logic                       i_done,
  input  logic                       i_clr,
  output logic [XW-1:0]              o_x,
  output logic                       o_srdyo,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic                       o_timeout,
  // Debug view of the issue FSM: 0 = IDLE, 1 = ISSUE, 2 = WAIT.
  output logic [1:0]                 o_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wd;
  logic            wr_en, pop, wd_clr, wd_inc, to_fire, empty;

  // Full/empty are decoded from the registered occupancy only.
  assign o_full  = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = i_srdyi & ~o_full;
  assign o_count = count;
  assign o_srdyo = (state == S_ISSUE);
  assign o_state = state;

  // Issue FSM next-state and control decode.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    to_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_clr    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_done) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (wd == WW'(TIMEOUT - 1)) begin
          // This is WAIT cycle TIMEOUT: the sample is abandoned.
          to_fire   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Watchdog: cleared while issuing, counts WAIT cycles without completion.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  wd <= '0;
    else if (wd_clr) wd <= '0;
    else if (wd_inc) wd <= wd + WW'(1);
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_x;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)   rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output sample register, loaded only when an entry is popped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_x <= '0;
    else if (pop)   o_x <= mem[rd_ptr];
  end

  // Sticky flags: a set condition wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      if (i_srdyi && o_full) o_overflow <= 1'b1;
      else if (i_clr)        o_overflow <= 1'b0;
      if (to_fire)           o_timeout  <= 1'b1;
      else if (i_clr)        o_timeout  <= 1'b0;
    end
  end

endmodule
